window_3x3_gen: RTL
===================

WINDOW_3X3_GEN -- requirements
Module: window_3x3_gen

Interface
REQ-001 SHALL have parameter Datawidth, default 8, meaning pixel width in bits.
REQ-002 SHALL have parameter Img_W, default 512, meaning pixels per image row (legal minimum 3).
REQ-003 SHALL have parameter Img_H, default 512, meaning rows per image (legal minimum 3).
REQ-004 SHALL have port clk  input  1  meaning the single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  meaning a synchronous, active-high reset.
REQ-006 SHALL have port in_img_data  input  Datawidth  meaning the raster-order pixel stream (row-major, col 0 first).
REQ-007 SHALL have port img_valid  input  1  meaning in_img_data carries a pixel this cycle.
REQ-008 SHALL have port win_data  output  9*Datawidth  meaning the 3x3 window; slice k=3*m+n at bits [k*Datawidth +: Datawidth] holds pixel(row r-2+m, col c-2+n).
REQ-009 SHALL have port win_valid  output  1  meaning win_data holds a complete window this cycle.
REQ-010 SHALL have port win_row  output  clog2(Img_H)  meaning the centre row index (r-1) of the current window.
REQ-011 SHALL have port win_col  output  clog2(Img_W)  meaning the centre column index (c-1) of the current window.

Function
REQ-012 SHALL keep a column counter (0..Img_W-1) and a row counter (0..Img_H-1) that advance only on cycles with img_valid=1.
REQ-013 SHALL wrap the column counter from Img_W-1 to 0 and then increment the row counter; from (Img_H-1, Img_W-1) both SHALL return to 0 for the next frame.
REQ-014 SHALL store two full rows in line buffers of depth Img_W, each written at the column-counter address; the write to a given address SHALL occur after the read from that address in the same accepted cycle.
REQ-015 SHALL shift a 3x3 register array by one column on every accepted pixel, loading the new column from {line buffer 2, line buffer 1, in_img_data}.
REQ-016 SHALL assert win_valid for exactly one cycle, the cycle after accepting pixel (r,c) with r>=2 and c>=2 (latency 1), so each frame yields (Img_W-2)*(Img_H-2) windows.
REQ-017 SHALL keep win_valid at 0 for columns 0 and 1 of each row, so no window spans a row boundary.
REQ-018 SHALL, while img_valid=0, hold all counters, line buffers and window registers, and drive win_valid=0.
REQ-019 SHALL accept back-to-back pixels every cycle with no backpressure; gaps in img_valid of any length SHALL NOT change window contents.
REQ-020 SHALL leave win_data, win_row and win_col unchanged on cycles with win_valid=0.

Reset
REQ-021 SHALL, on reset=1 at a rising edge, clear row and column counters, win_valid, win_row, win_col, win_data and any frame flag to 0.
REQ-022 SHALL NOT clear line buffer contents on reset; stale contents SHALL never reach a valid window, because windows require two fresh rows.
REQ-023 SHALL treat reset asserted mid-frame as a frame abort: the first pixel accepted after reset is pixel (0,0) of a new frame.
REQ-024 SHALL give reset priority over img_valid in the same cycle; that pixel is discarded.

Configuration
REQ-025 SHALL use macro WIN_FRAME_DONE_EN to control frame-completion signalling.
REQ-026 With WIN_FRAME_DONE_EN defined, SHALL add output frame_done (1 bit) pulsing high for one cycle coincident with win_valid of window (Img_H-2, Img_W-2), reset value 0.
REQ-027 Without WIN_FRAME_DONE_EN, SHALL omit the frame_done port and its logic, with all other behaviour identical.

Verification
REQ-028 SHALL pass: Img_W=8, Img_H=6, pixel(r,c)=r*8+c streamed continuously -> 24 win_valid pulses; first window slices 0,1,2,8,9,10,16,17,18, win_row=1, win_col=1.
REQ-029 SHALL pass: same ramp with img_valid dropped for 3 cycles after every 5th pixel -> identical window sequence, win_valid never high during gaps.
REQ-030 SHALL pass: two back-to-back frames (second frame = first + 100) -> second frame's first window centre 109, no window mixing frames.
REQ-031 SHALL pass: reset for 1 cycle after pixel (3,4), then full fresh frame -> no win_valid until pixel (2,2) of the new frame; windows match the ramp exactly.
REQ-032 SHALL pass: with WIN_FRAME_DONE_EN, 8x6 frame -> frame_done high exactly once, same cycle as window with win_row=4, win_col=6; without the macro the design elaborates with no frame_done port.
REQ-033 SHALL pass: reset and img_valid high in the same cycle with data 0xFF -> pixel discarded, counters remain 0.

Source files
------------

// File: rtl/window_3x3_gen.sv
// rtl/window_3x3_gen.sv - 3x3 sliding window generator over a raster pixel stream
//
// Purpose:
//   Builds a 3x3 pixel neighbourhood from a row-major pixel stream using two
//   line buffers and a 3x3 shift array. A registered window is presented one
//   cycle after each pixel (r,c) with r>=2 and c>=2 is accepted.
//
// Parameters:
//   Datawidth - pixel width in bits
//   Img_W     - pixels per row (>= 3)
//   Img_H     - rows per image (>= 3)
//
// Ports:
//   clk         - clock, rising edge
//   reset       - synchronous active-high reset (frame abort)
//   in_img_data - incoming pixel
//   img_valid   - in_img_data carries a pixel this cycle
//   win_data    - 3x3 window, slice 3*m+n = pixel(r-2+m, c-2+n)
//   win_valid   - win_data holds a complete window this cycle
//   win_row     - centre row index of the window
//   win_col     - centre column index of the window
//   frame_done  - (only with WIN_FRAME_DONE_EN) pulses with the last window
//
// Configuration macro: WIN_FRAME_DONE_EN adds the frame_done output.

module window_3x3_gen #(
    parameter int Datawidth = 8,
    parameter int Img_W     = 512,
    parameter int Img_H     = 512
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [Datawidth-1:0]         in_img_data,
    input  logic                         img_valid,
    output logic [9*Datawidth-1:0]       win_data,
    output logic                         win_valid,
    output logic [$clog2(Img_H)-1:0]     win_row,
    output logic [$clog2(Img_W)-1:0]     win_col
`ifdef WIN_FRAME_DONE_EN
    ,
    output logic                         frame_done
`endif
);

    localparam int CW = $clog2(Img_W);
    localparam int RW = $clog2(Img_H);

    localparam logic [CW-1:0] COL_LAST = CW'(Img_W - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(Img_H - 1);
    localparam logic [CW-1:0] COL_TWO  = CW'(2);
    localparam logic [RW-1:0] ROW_TWO  = RW'(2);

    logic [CW-1:0]            col_q, col_d;
    logic [RW-1:0]            row_q, row_d;
    logic [9*Datawidth-1:0]   win_q, win_d;
    logic [9*Datawidth-1:0]   win_data_q, win_data_d;
    logic                     win_valid_q, win_valid_d;
    logic [RW-1:0]            win_row_q, win_row_d;
    logic [CW-1:0]            win_col_q, win_col_d;
`ifdef WIN_FRAME_DONE_EN
    logic                     frame_done_q, frame_done_d;
`endif

    // lb1 holds the previous row, lb2 the row before that. Not reset: a
    // window needs two fresh rows, so stale contents never reach the output.
    logic [Datawidth-1:0] lb1_mem [Img_W];
    logic [Datawidth-1:0] lb2_mem [Img_W];
    logic [Datawidth-1:0] lb1_rd, lb2_rd;

    always_comb begin
        lb1_rd = lb1_mem[col_q];
        lb2_rd = lb2_mem[col_q];
    end

    // Read happens combinationally above; the non-blocking writes below land
    // after it, so each address is read before it is overwritten. The row in
    // lb1 cascades into lb2 as the new row enters lb1.
    always_ff @(posedge clk) begin
        if (!reset && img_valid) begin
            lb1_mem[col_q] <= in_img_data;
            lb2_mem[col_q] <= lb1_rd;
        end
    end

    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        win_d       = win_q;
        win_data_d  = win_data_q;
        win_valid_d = 1'b0;
        win_row_d   = win_row_q;
        win_col_d   = win_col_q;
`ifdef WIN_FRAME_DONE_EN
        frame_done_d = 1'b0;
`endif
        if (img_valid) begin
            if (col_q == COL_LAST) begin
                col_d = '0;
                row_d = (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            // Shift columns left (n=0 oldest), new column enters at n=2.
            for (int m = 0; m < 3; m++) begin
                for (int n = 0; n < 2; n++) begin
                    win_d[(3*m+n)*Datawidth +: Datawidth] =
                        win_q[(3*m+n+1)*Datawidth +: Datawidth];
                end
            end
            win_d[2*Datawidth +: Datawidth] = lb2_rd;
            win_d[5*Datawidth +: Datawidth] = lb1_rd;
            win_d[8*Datawidth +: Datawidth] = in_img_data;

            // Columns 0/1 are excluded so a window never straddles two rows.
            if (row_q >= ROW_TWO && col_q >= COL_TWO) begin
                win_valid_d = 1'b1;
                win_data_d  = win_d;
                win_row_d   = row_q - 1'b1;
                win_col_d   = col_q - 1'b1;
`ifdef WIN_FRAME_DONE_EN
                frame_done_d = (row_q == ROW_LAST) && (col_q == COL_LAST);
`endif
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            win_q       <= '0;
            win_data_q  <= '0;
            win_valid_q <= 1'b0;
            win_row_q   <= '0;
            win_col_q   <= '0;
`ifdef WIN_FRAME_DONE_EN
            frame_done_q <= 1'b0;
`endif
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            win_q       <= win_d;
            win_data_q  <= win_data_d;
            win_valid_q <= win_valid_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
`ifdef WIN_FRAME_DONE_EN
            frame_done_q <= frame_done_d;
`endif
        end
    end

    assign win_data  = win_data_q;
    assign win_valid = win_valid_q;
    assign win_row   = win_row_q;
    assign win_col   = win_col_q;
`ifdef WIN_FRAME_DONE_EN
    assign frame_done = frame_done_q;
`endif

endmodule
